// File: rtl/id_hazard_stage.sv
// Decode stage: IF/ID + ID/EX registers with load-use hazard detection.
// Optional ID_HAZARD_STATS_EN adds saturating stall/flush counters.
module id_hazard_stage #(
  parameter int DW       = 32,
  parameter int CW       = 15,
  parameter int LOAD_BIT = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] if_pc,
  input  logic [DW-1:0] if_instr,
  input  logic          if_valid,
  input  logic [CW-1:0] cu_ctrl,
  input  logic          hold,
  input  logic          flush,
  output logic          le_pc,
  output logic          le_npc,
  output logic [DW-1:0] id_instr,
  output logic [DW-1:0] id_pc,
  output logic          id_valid,
  output logic [CW-1:0] ex_ctrl,
  output logic [DW-1:0] ex_pc,
  output logic [4:0]    ex_rs,
  output logic [4:0]    ex_rt,
  output logic [4:0]    ex_rd,
  output logic [15:0]   ex_imm,
  output logic          ex_valid,
`ifdef ID_HAZARD_STATS_EN
  output logic [15:0]   stall_cnt,
  output logic [15:0]   flush_cnt,
`endif
  output logic          lu_stall
);

  typedef struct packed {
    logic [DW-1:0] pc;
    logic [DW-1:0] instr;
    logic          valid;
  } if_id_t;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] pc;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic [15:0]   imm;
    logic          valid;
  } id_ex_t;

  if_id_t if_id_q, if_id_d;
  id_ex_t id_ex_q, id_ex_d;
  id_ex_t adv_ex;

  // Load in EX whose rt feeds either source field of the ID instruction.
  always_comb begin
    lu_stall = if_id_q.valid & id_ex_q.valid
             & id_ex_q.ctrl[LOAD_BIT]
             & (id_ex_q.rt != 5'd0)
             & ((id_ex_q.rt == if_id_q.instr[25:21])
              | (id_ex_q.rt == if_id_q.instr[20:16]));
  end

  assign le_pc  = ~(lu_stall | hold) & ~reset;
  assign le_npc = le_pc;

  // Next-state for both pipeline registers by edge priority.
  always_comb begin
    if_id_d = if_id_q;
    id_ex_d = id_ex_q;
    adv_ex  = '0;
    if (if_id_q.valid) begin
      adv_ex.ctrl  = cu_ctrl;
      adv_ex.pc    = if_id_q.pc;
      adv_ex.rs    = if_id_q.instr[25:21];
      adv_ex.rt    = if_id_q.instr[20:16];
      adv_ex.rd    = if_id_q.instr[15:11];
      adv_ex.imm   = if_id_q.instr[15:0];
      adv_ex.valid = 1'b1;
    end
    priority case (1'b1)
      flush: begin
        if_id_d = '0;
        id_ex_d = '0;
      end
      hold: begin
      end
      lu_stall: begin
        id_ex_d = '0;
      end
      default: begin
        if_id_d.pc    = if_pc;
        if_id_d.instr = if_instr;
        if_id_d.valid = if_valid;
        id_ex_d       = adv_ex;
      end
    endcase
  end

  // Pipeline registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_id_q <= '0;
      id_ex_q <= '0;
    end else begin
      if_id_q <= if_id_d;
      id_ex_q <= id_ex_d;
    end
  end

  assign id_instr = if_id_q.instr;
  assign id_pc    = if_id_q.pc;
  assign id_valid = if_id_q.valid;
  assign ex_ctrl  = id_ex_q.ctrl;
  assign ex_pc    = id_ex_q.pc;
  assign ex_rs    = id_ex_q.rs;
  assign ex_rt    = id_ex_q.rt;
  assign ex_rd    = id_ex_q.rd;
  assign ex_imm   = id_ex_q.imm;
  assign ex_valid = id_ex_q.valid;

`ifdef ID_HAZARD_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Saturating counters; a stall only counts when it really took effect.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (lu_stall & ~hold & ~flush & ~&stall_cnt_q)
      stall_cnt_d = stall_cnt_q + 16'd1;
    if (flush & ~&flush_cnt_q)
      flush_cnt_d = flush_cnt_q + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_hazard_stage.sv
// Randomized bench for id_hazard_stage against a two-slot pipeline model.
// Stats checks compile only with ID_HAZARD_STATS_EN.
module tb_id_hazard_stage;

  localparam int DW = 32;
  localparam int CW = 15;
  localparam int LB = 10;

  localparam logic [31:0] LW21   = 32'h8C22_0000;
  localparam logic [31:0] LW01   = 32'h8C20_0000;
  localparam logic [31:0] ADDU   = 32'h0044_1821;

  logic          clk = 1'b0;
  logic          reset, if_valid, hold, flush;
  logic [DW-1:0] if_pc, if_instr;
  logic [CW-1:0] cu_ctrl;
  logic          le_pc, le_npc, id_valid, ex_valid;
  logic          lu_stall;
  logic [DW-1:0] id_instr, id_pc, ex_pc;
  logic [CW-1:0] ex_ctrl;
  logic [4:0]    ex_rs, ex_rt, ex_rd;
  logic [15:0]   ex_imm;
`ifdef ID_HAZARD_STATS_EN
  logic [15:0]   stall_cnt, flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_hazard_stage #(.DW(DW), .CW(CW), .LOAD_BIT(LB)) dut (
    .clk(clk), .reset(reset),
    .if_pc(if_pc), .if_instr(if_instr),
    .if_valid(if_valid), .cu_ctrl(cu_ctrl),
    .hold(hold), .flush(flush),
    .le_pc(le_pc), .le_npc(le_npc),
    .id_instr(id_instr), .id_pc(id_pc),
    .id_valid(id_valid), .ex_ctrl(ex_ctrl),
    .ex_pc(ex_pc), .ex_rs(ex_rs),
    .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_imm(ex_imm), .ex_valid(ex_valid),
`ifdef ID_HAZARD_STATS_EN
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt),
`endif
    .lu_stall(lu_stall)
  );

  function automatic logic [CW-1:0] cu_fn(
    input logic [31:0] ins);
    logic [CW-1:0] c;
    c     = ins[14:0];
    c[LB] = (ins[31:26] == 6'h23);
    c[9]  = 1'b1;
    return c;
  endfunction

  assign cu_ctrl = cu_fn(id_instr);

  // reference model state
  logic [31:0] m_id_pc, m_id_ins, m_ex_pc, m_ex_ins;
  logic [CW-1:0] m_ex_ctrl;
  logic m_id_v, m_ex_v;
  int m_scnt, m_fcnt;

  function automatic logic m_stall();
    logic [4:0] lrt;
    lrt = m_ex_ins[20:16];
    return m_id_v && m_ex_v && m_ex_ctrl[LB]
        && lrt != 0
        && (lrt == m_id_ins[25:21]
         || lrt == m_id_ins[20:16]);
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic m_clear();
    m_id_pc = 0; m_id_ins = 0; m_id_v = 0;
    m_ex_pc = 0; m_ex_ins = 0; m_ex_v = 0;
    m_ex_ctrl = 0;
  endtask

  task automatic model_edge();
    logic st;
    st = m_stall();
    if (reset) begin
      m_clear();
      m_scnt = 0; m_fcnt = 0;
    end else if (flush) begin
      m_clear();
      if (m_fcnt < 65535) m_fcnt++;
    end else if (hold) begin
    end else if (st) begin
      m_ex_pc = 0; m_ex_ins = 0;
      m_ex_v = 0; m_ex_ctrl = 0;
      if (m_scnt < 65535) m_scnt++;
    end else begin
      m_ex_v    = m_id_v;
      m_ex_pc   = m_id_v ? m_id_pc : 0;
      m_ex_ins  = m_id_v ? m_id_ins : 0;
      m_ex_ctrl = m_id_v ? cu_fn(m_id_ins) : 0;
      m_id_pc   = if_pc;
      m_id_ins  = if_instr;
      m_id_v    = if_valid;
    end
  endtask

  task automatic check_regs();
    chk("id_instr", id_instr, m_id_ins);
    chk("id_pc", id_pc, m_id_pc);
    chk("id_valid", id_valid, m_id_v);
    chk("ex_ctrl", ex_ctrl, m_ex_ctrl);
    chk("ex_pc", ex_pc, m_ex_pc);
    chk("ex_rs", ex_rs, m_ex_ins[25:21]);
    chk("ex_rt", ex_rt, m_ex_ins[20:16]);
    chk("ex_rd", ex_rd, m_ex_ins[15:11]);
    chk("ex_imm", ex_imm, m_ex_ins[15:0]);
    chk("ex_valid", ex_valid, m_ex_v);
`ifdef ID_HAZARD_STATS_EN
    chk("stall_cnt", stall_cnt, m_scnt);
    chk("flush_cnt", flush_cnt, m_fcnt);
`endif
  endtask

  task automatic cycle();
    logic le;
    #1;
    le = !(m_stall() || hold) && !reset;
    chk("lu_stall", lu_stall, m_stall());
    chk("le_pc", le_pc, le);
    chk("le_npc", le_npc, le);
    @(posedge clk);
    model_edge();
    #1;
    check_regs();
  endtask

  task automatic fetch(input logic [31:0] pc,
                       input logic [31:0] ins,
                       input logic v);
    reset = 0; hold = 0; flush = 0;
    if_pc = pc; if_instr = ins; if_valid = v;
    cycle();
  endtask

  task automatic do_reset();
    reset = 1; hold = 0; flush = 0;
    if_valid = 1; if_pc = 32'h40;
    if_instr = ADDU;
    cycle();
    cycle();
    reset = 0;
  endtask

  function automatic logic [31:0] rnd_ins();
    logic [31:0] w;
    logic [5:0] op;
    w = $urandom;
    case ($urandom_range(0, 2))
      0: op = 6'h23;
      1: op = 6'h00;
      default: op = 6'h2B;
    endcase
    w[31:26] = op;
    w[25:21] = 5'($urandom_range(0, 3));
    w[20:16] = 5'($urandom_range(0, 3));
    return w;
  endfunction

  initial begin
    m_clear();
    m_scnt = 0; m_fcnt = 0;
    reset = 1; hold = 0; flush = 0;
    if_valid = 0; if_pc = 0; if_instr = 0;

    // 1 reset
    do_reset();
    #1;
    chk("rst_idv", id_valid, 0);
    chk("rst_exv", ex_valid, 0);
    chk("rst_le", le_pc, 1);
    chk("rst_st", lu_stall, 0);

    // 2 stream
    fetch(0, ADDU, 1);
    fetch(4, ADDU, 1);
    chk("s_pc0", ex_pc, 0);
    chk("s_v0", ex_valid, 1);
    fetch(8, ADDU, 1);
    chk("s_pc4", ex_pc, 4);
    fetch(12, 0, 0);
    chk("s_pc8", ex_pc, 8);
    fetch(16, 0, 0);

    // 3 load-use
    fetch(20, LW21, 1);
    fetch(24, ADDU, 1);
    chk("lu_on", lu_stall, 1);
    chk("lu_le", le_pc, 0);
    fetch(28, 0, 0);
    chk("lu_bub", ex_valid, 0);
    chk("lu_off", lu_stall, 0);
    fetch(28, 0, 0);
    chk("lu_add", ex_pc, 24);
    chk("lu_addv", ex_valid, 1);
    fetch(32, LW01, 1);
    fetch(36, ADDU, 1);
    chk("lw0_st", lu_stall, 0);
    fetch(40, 0, 0);
    chk("lw0_ex", ex_pc, 36);

    // 4 hold vs stall
    fetch(44, LW21, 1);
    fetch(48, ADDU, 1);
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("h_st", lu_stall, 1);
      chk("h_exv", ex_valid, 1);
      chk("h_expc", ex_pc, 44);
    end
    fetch(52, 0, 0);
    chk("h_bub", ex_valid, 0);
    fetch(52, 0, 0);
    chk("h_add", ex_pc, 48);

    // 5 flush with hold
    do_reset();
    fetch(60, ADDU, 1);
    fetch(64, ADDU, 1);
    hold = 1; flush = 1;
    cycle();
    chk("f_idv", id_valid, 0);
    chk("f_exv", ex_valid, 0);
`ifdef ID_HAZARD_STATS_EN
    chk("f_cnt", flush_cnt, 1);

    // 6 saturation
    force dut.stall_cnt_q = 16'hFFFE;
    #1;
    release dut.stall_cnt_q;
    m_scnt = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      fetch(100, LW21, 1);
      fetch(104, ADDU, 1);
      fetch(108, 0, 0);
    end
    chk("sat", stall_cnt, 16'hFFFF);
`endif

    // random
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      reset    = ($urandom_range(0, 99) < 2);
      flush    = ($urandom_range(0, 99) < 5);
      hold     = ($urandom_range(0, 99) < 12);
      if_valid = ($urandom_range(0, 9) != 0);
      if_pc    = $urandom;
      if_instr = rnd_ins();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
